// File: rtl/mcpu_pkg.sv
// Shared size constants, opcode encodings and FSM state type for the mcpu micro-CPU.
package mcpu_pkg;

  localparam int unsigned WORD_SIZE        = 16;
  localparam int unsigned INSTRUCTION_SIZE = 16;
  localparam int unsigned OPCODE_SIZE      = 4;
  localparam int unsigned OPERAND_SIZE     = 4;

  localparam logic [3:0] OP_NOP           = 4'd0;
  localparam logic [3:0] OP_SHORT_TO_REG  = 4'd1;
  localparam logic [3:0] OP_STORE_TO_MEM  = 4'd2;
  localparam logic [3:0] OP_LOAD_FROM_MEM = 4'd3;
  localparam logic [3:0] OP_ADD           = 4'd4;
  localparam logic [3:0] OP_SUB           = 4'd5;
  localparam logic [3:0] OP_AND           = 4'd6;
  localparam logic [3:0] OP_OR            = 4'd7;
  localparam logic [3:0] OP_XOR           = 4'd8;
  localparam logic [3:0] OP_NOT           = 4'd9;
  localparam logic [3:0] OP_LSL           = 4'd10;
  localparam logic [3:0] OP_LSR           = 4'd11;
  localparam logic [3:0] OP_MOV           = 4'd12;
  localparam logic [3:0] OP_BRANCH_ZERO   = 4'd13;
  localparam logic [3:0] OP_JUMP          = 4'd14;
  localparam logic [3:0] OP_HALT          = 4'd15;

  typedef enum logic [1:0] {
    StFetch,
    StExecute,
    StHalted
  } state_e;

endpackage

// File: rtl/mcpu_ram.sv
// Unified instruction/data RAM: combinational read, write on the rising clock edge, never reset.
module mcpu_ram
  import mcpu_pkg::*;
#(
  parameter int unsigned RAM_SIZE = 256
) (
  input  logic                         clk,
  input  logic [$clog2(RAM_SIZE)-1:0]  addr,
  input  logic                         we,
  input  logic [WORD_SIZE-1:0]         wdata,
  output logic [WORD_SIZE-1:0]         rdata
);

  logic [WORD_SIZE-1:0] mem [0:RAM_SIZE-1];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/mcpu_regfile.sv
// 16-entry register file: two combinational read ports, one synchronous write port, never reset.
module mcpu_regfile
  import mcpu_pkg::*;
(
  input  logic                    clk,
  input  logic [OPERAND_SIZE-1:0] ra_addr,
  input  logic [OPERAND_SIZE-1:0] rb_addr,
  output logic [WORD_SIZE-1:0]    ra_data,
  output logic [WORD_SIZE-1:0]    rb_data,
  input  logic                    we,
  input  logic [OPERAND_SIZE-1:0] waddr,
  input  logic [WORD_SIZE-1:0]    wdata
);

  logic [WORD_SIZE-1:0] R [0:15];

  assign ra_data = R[ra_addr];
  assign rb_data = R[rb_addr];

  always_ff @(posedge clk) begin
    if (we) begin
      R[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/mcpu.sv
// 16-bit micro-CPU top: fetch/execute FSM and ALU around mcpu_ram and mcpu_regfile.
// Define MCPU_BRANCH_EN to enable BRANCH_ZERO and JUMP; otherwise they behave as NOP.
module mcpu
  import mcpu_pkg::*;
(
  input logic clk,
  input logic reset
);

  localparam int unsigned WORD_SIZE        = mcpu_pkg::WORD_SIZE;
  localparam int unsigned INSTRUCTION_SIZE = mcpu_pkg::INSTRUCTION_SIZE;
  localparam int unsigned OPCODE_SIZE      = mcpu_pkg::OPCODE_SIZE;
  localparam int unsigned OPERAND_SIZE     = mcpu_pkg::OPERAND_SIZE;

  localparam logic [3:0] OP_NOP           = mcpu_pkg::OP_NOP;
  localparam logic [3:0] OP_SHORT_TO_REG  = mcpu_pkg::OP_SHORT_TO_REG;
  localparam logic [3:0] OP_STORE_TO_MEM  = mcpu_pkg::OP_STORE_TO_MEM;
  localparam logic [3:0] OP_LOAD_FROM_MEM = mcpu_pkg::OP_LOAD_FROM_MEM;
  localparam logic [3:0] OP_ADD           = mcpu_pkg::OP_ADD;
  localparam logic [3:0] OP_SUB           = mcpu_pkg::OP_SUB;
  localparam logic [3:0] OP_AND           = mcpu_pkg::OP_AND;
  localparam logic [3:0] OP_OR            = mcpu_pkg::OP_OR;
  localparam logic [3:0] OP_XOR           = mcpu_pkg::OP_XOR;
  localparam logic [3:0] OP_NOT           = mcpu_pkg::OP_NOT;
  localparam logic [3:0] OP_LSL           = mcpu_pkg::OP_LSL;
  localparam logic [3:0] OP_LSR           = mcpu_pkg::OP_LSR;
  localparam logic [3:0] OP_MOV           = mcpu_pkg::OP_MOV;
  localparam logic [3:0] OP_BRANCH_ZERO   = mcpu_pkg::OP_BRANCH_ZERO;
  localparam logic [3:0] OP_JUMP          = mcpu_pkg::OP_JUMP;
  localparam logic [3:0] OP_HALT          = mcpu_pkg::OP_HALT;

  state_e                      state_q, state_d;
  logic [7:0]                  pc_q, pc_d;
  logic [INSTRUCTION_SIZE-1:0] ir_q, ir_d;

  logic [OPCODE_SIZE-1:0]  op;
  logic [OPERAND_SIZE-1:0] rd_idx, ra_idx, rb_idx;
  logic [7:0]              imm;

  logic [OPERAND_SIZE-1:0] rf_ra_addr;
  logic [WORD_SIZE-1:0]    ra_data, rb_data;
  logic                    rf_we;
  logic [WORD_SIZE-1:0]    rf_wdata;

  logic [7:0]              ram_addr;
  logic                    ram_we;
  logic [WORD_SIZE-1:0]    ram_rdata;

  logic [WORD_SIZE-1:0]    alu;
  logic                    shift_big;

  assign op     = ir_q[15:12];
  assign rd_idx = ir_q[11:8];
  assign ra_idx = ir_q[7:4];
  assign rb_idx = ir_q[3:0];
  assign imm    = ir_q[7:0];

  // I-type instructions that read a register take it from the Rd field.
  assign rf_ra_addr = (op == OP_STORE_TO_MEM || op == OP_BRANCH_ZERO) ? rd_idx : ra_idx;

  mcpu_regfile regfileinst (
    .clk     (clk),
    .ra_addr (rf_ra_addr),
    .rb_addr (rb_idx),
    .ra_data (ra_data),
    .rb_data (rb_data),
    .we      (rf_we),
    .waddr   (rd_idx),
    .wdata   (rf_wdata)
  );

  mcpu_ram #(
    .RAM_SIZE (256)
  ) raminst (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .wdata (ra_data),
    .rdata (ram_rdata)
  );

  // The shift amount is the full 16-bit Rb, so anything >= 16 clears the result.
  assign shift_big = |rb_data[WORD_SIZE-1:4];

  always_comb begin
    alu = '0;
    case (op)
      OP_ADD:  alu = ra_data + rb_data;
      OP_SUB:  alu = ra_data - rb_data;
      OP_AND:  alu = ra_data & rb_data;
      OP_OR:   alu = ra_data | rb_data;
      OP_XOR:  alu = ra_data ^ rb_data;
      OP_NOT:  alu = ~ra_data;
      OP_LSL:  alu = shift_big ? '0 : ra_data << rb_data[3:0];
      OP_LSR:  alu = shift_big ? '0 : ra_data >> rb_data[3:0];
      OP_MOV:  alu = ra_data;
      default: alu = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    rf_we    = 1'b0;
    rf_wdata = alu;
    ram_we   = 1'b0;
    ram_addr = imm;
    unique case (state_q)
      StFetch: begin
        ram_addr = pc_q;
        ir_d     = ram_rdata;
        state_d  = StExecute;
      end
      StExecute: begin
        pc_d    = pc_q + 8'd1;
        state_d = StFetch;
        case (op)
          OP_SHORT_TO_REG: begin
            rf_we    = 1'b1;
            rf_wdata = {8'h00, imm};
          end
          OP_STORE_TO_MEM: ram_we = 1'b1;
          OP_LOAD_FROM_MEM: begin
            rf_we    = 1'b1;
            rf_wdata = ram_rdata;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_LSL, OP_LSR, OP_MOV: rf_we = 1'b1;
`ifdef MCPU_BRANCH_EN
          OP_BRANCH_ZERO: begin
            if (ra_data == '0) pc_d = imm;
          end
          OP_JUMP: pc_d = imm;
`endif
          OP_HALT: begin
            pc_d    = pc_q;
            state_d = StHalted;
          end
          default: ;
        endcase
      end
      StHalted: ;
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

endmodule

// File: tb/tb_mcpu.sv
// Self-checking bench for mcpu: directed programs plus random programs against an ISA-level model.
module tb_mcpu;
  import mcpu_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;

  int checks = 0;
  int errors = 0;

`ifdef MCPU_BRANCH_EN
  localparam bit BranchEn = 1'b1;
`else
  localparam bit BranchEn = 1'b0;
`endif

  mcpu dut (
    .clk   (clk),
    .reset (reset)
  );

  always #5 clk = ~clk;

  // ISA-level reference state
  logic [15:0] m_r   [0:15];
  logic [15:0] m_mem [0:255];
  logic [7:0]  m_pc;
  bit          m_halt;
  logic [15:0] img   [0:255];

  function automatic logic [15:0] r_ins(input int op, input int d, input int a, input int b);
    logic [15:0] w;
    w = {op[3:0], d[3:0], a[3:0], b[3:0]};
    return w;
  endfunction

  function automatic logic [15:0] i_ins(input int op, input int r, input int imm);
    logic [15:0] w;
    w = {op[3:0], r[3:0], imm[7:0]};
    return w;
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    logic [15:0] ins, a, b;
    logic [7:0]  nxt, addr;
    int          rd;
    if (m_halt) return;
    ins  = m_mem[m_pc];
    rd   = int'(ins[11:8]);
    addr = ins[7:0];
    a    = m_r[ins[7:4]];
    b    = m_r[ins[3:0]];
    nxt  = m_pc + 8'd1;
    case (ins[15:12])
      4'd1:  m_r[rd] = {8'h00, addr};
      4'd2:  m_mem[addr] = m_r[rd];
      4'd3:  m_r[rd] = m_mem[addr];
      4'd4:  m_r[rd] = a + b;
      4'd5:  m_r[rd] = a - b;
      4'd6:  m_r[rd] = a & b;
      4'd7:  m_r[rd] = a | b;
      4'd8:  m_r[rd] = a ^ b;
      4'd9:  m_r[rd] = ~a;
      4'd10: m_r[rd] = (b >= 16) ? 16'h0 : 16'(a << b);
      4'd11: m_r[rd] = (b >= 16) ? 16'h0 : 16'(a >> b);
      4'd12: m_r[rd] = a;
      4'd13: if (BranchEn && m_r[rd] == 16'h0) nxt = addr;
      4'd14: if (BranchEn) nxt = addr;
      4'd15: begin
        m_halt = 1'b1;
        nxt    = m_pc;
      end
      default: ;
    endcase
    m_pc = nxt;
  endtask

  task automatic clear_img();
    for (int i = 0; i < 256; i++) img[i] = 16'h0000;
  endtask

  // Load img into RAM and the model while reset is held, then release on a falling edge.
  task automatic start();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 256; i++) begin
      dut.raminst.mem[i] = img[i];
      m_mem[i] = img[i];
    end
    m_pc   = 8'd0;
    m_halt = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
    for (int i = 0; i < cycles / 2; i++) model_step();
  endtask

  task automatic compare_all(input string tag);
    chk($sformatf("%s.pc", tag), {8'h00, dut.pc_q}, {8'h00, m_pc});
    chk($sformatf("%s.halted", tag), {15'h0, dut.state_q == StHalted}, {15'h0, m_halt});
    for (int i = 0; i < 16; i++)
      chk($sformatf("%s.R%0d", tag, i), dut.regfileinst.R[i], m_r[i]);
    for (int i = 0; i < 256; i++)
      chk($sformatf("%s.mem%0d", tag, i), dut.raminst.mem[i], m_mem[i]);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m_r[i] = 16'hxxxx;

    // Reset state
    clear_img();
    @(negedge clk);
    #1;
    chk("reset.pc", {8'h00, dut.pc_q}, 16'h0000);
    chk("reset.ir", dut.ir_q, 16'h0000);
    chk("reset.state", {14'h0, dut.state_q}, {14'h0, StFetch});

    // Register load: Rn = n
    clear_img();
    for (int i = 0; i < 16; i++) img[i] = i_ins(1, i, i);
    start();
    run(32);
    chk("regload.pc", {8'h00, dut.pc_q}, 16'd16);
    for (int i = 0; i < 16; i++) chk($sformatf("regload.R%0d", i), dut.regfileinst.R[i], 16'(i));
    compare_all("regload");

    // Shift/add chain
    clear_img();
    img[0]  = i_ins(1, 2, 2);
    img[1]  = i_ins(1, 3, 150);
    img[2]  = i_ins(1, 5, 5);
    img[3]  = i_ins(1, 11, 19);
    img[4]  = r_ins(10, 13, 3, 5);
    img[5]  = r_ins(4, 14, 13, 11);
    img[6]  = r_ins(10, 9, 14, 2);
    img[7]  = r_ins(11, 10, 14, 2);
    img[8]  = i_ins(2, 9, 20);
    img[9]  = i_ins(2, 10, 21);
    img[10] = i_ins(15, 0, 0);
    start();
    run(30);
    chk("chain.R13", dut.regfileinst.R[13], 16'd4800);
    chk("chain.R14", dut.regfileinst.R[14], 16'd4819);
    chk("chain.mem20", dut.raminst.mem[20], 16'h4B4C);
    chk("chain.mem21", dut.raminst.mem[21], 16'h04B4);
    compare_all("chain");

    // Arithmetic edges
    clear_img();
    img[0] = i_ins(1, 1, 1);
    img[1] = i_ins(1, 2, 0);
    img[2] = i_ins(1, 5, 16);
    img[3] = r_ins(5, 3, 2, 1);
    img[4] = r_ins(10, 4, 1, 5);
    img[5] = r_ins(9, 6, 2, 0);
    img[6] = i_ins(15, 0, 0);
    start();
    run(20);
    chk("arith.sub", dut.regfileinst.R[3], 16'hFFFF);
    chk("arith.lsl16", dut.regfileinst.R[4], 16'h0000);
    chk("arith.not", dut.regfileinst.R[6], 16'hFFFF);
    compare_all("arith");

    // Memory round trip, then a store that rewrites the next instruction to be fetched
    clear_img();
    img[0]  = i_ins(1, 7, 7);
    img[1]  = i_ins(2, 7, 200);
    img[2]  = i_ins(3, 8, 200);
    img[3]  = i_ins(1, 1, 8'h1C);
    img[4]  = i_ins(1, 2, 8);
    img[5]  = r_ins(10, 1, 1, 2);
    img[6]  = i_ins(1, 3, 8'h55);
    img[7]  = r_ins(7, 1, 1, 3);
    img[8]  = i_ins(2, 1, 9);
    img[9]  = i_ins(15, 0, 0);
    img[10] = i_ins(15, 0, 0);
    start();
    run(30);
    chk("mem.R8", dut.regfileinst.R[8], 16'd7);
    chk("mem.mem200", dut.raminst.mem[200], 16'd7);
    chk("mem.selfmod", dut.regfileinst.R[12], 16'h0055);
    chk("mem.pc", {8'h00, dut.pc_q}, 16'd10);
    compare_all("mem");

    // Branch / jump
    clear_img();
    img[0]  = i_ins(1, 1, 0);
    img[1]  = i_ins(13, 1, 10);
    img[2]  = i_ins(15, 0, 0);
    img[10] = i_ins(1, 2, 3);
    img[11] = i_ins(13, 2, 30);
    img[12] = i_ins(14, 0, 20);
    img[20] = i_ins(15, 0, 0);
    start();
    run(4);
    chk("branch.bz_pc", {8'h00, dut.pc_q}, BranchEn ? 16'd10 : 16'd2);
    run(16);
    chk("branch.final_pc", {8'h00, dut.pc_q}, BranchEn ? 16'd20 : 16'd2);
    compare_all("branch");

    // HALT at address 5 holds the PC
    clear_img();
    img[5] = i_ins(15, 0, 0);
    start();
    run(12);
    for (int c = 0; c < 20; c++) begin
      chk($sformatf("halt.pc%0d", c), {8'h00, dut.pc_q}, 16'd5);
      run(1);
    end
    chk("halt.state", {14'h0, dut.state_q}, {14'h0, StHalted});

    // Reset pulse during EXECUTE aborts the pending register write
    clear_img();
    img[0]   = i_ins(1, 4, 8'hAA);
    img[1]   = i_ins(2, 4, 100);
    img[2]   = i_ins(15, 0, 0);
    img[100] = 16'h1234;
    start();
    @(posedge clk);
    #1;
    chk("abort.in_exec", {14'h0, dut.state_q}, {14'h0, StExecute});
    reset = 1'b1;
    #1;
    chk("abort.pc", {8'h00, dut.pc_q}, 16'h0000);
    @(posedge clk);
    #1;
    chk("abort.R4", dut.regfileinst.R[4], m_r[4]);
    chk("abort.mem100", dut.raminst.mem[100], 16'h1234);
    chk("abort.mem0", dut.raminst.mem[0], img[0]);
    @(negedge clk);
    reset = 1'b0;
    m_pc   = 8'd0;
    m_halt = 1'b0;
    run(8);
    compare_all("abort_restart");

    // Random programs over the whole RAM image
    for (int p = 0; p < 8; p++) begin
      for (int i = 0; i < 256; i++) begin
        img[i] = 16'($urandom);
        if (img[i][15:12] == 4'd15 && $urandom_range(0, 3) != 0) img[i][15:12] = 4'd0;
      end
      start();
      run(200);
      compare_all($sformatf("rand%0d", p));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
